exec_cycle_ctrl: RTL and testbench
==================================

# exec_cycle_ctrl

Multi-cycle execution sequencer that owns the ALU and register-file control in the decode/execute path. It accepts one 32-bit instruction at a time over a valid/ready handshake and steps it through DECODE, EXECUTE, optional MEM and WRITEBACK. Along the way it drives register read addresses, the 2-bit ALU opcode, memory strobes and register write-back. It sits between the instruction source and the datapath (register file, ALU, data memory).

## Interface
- MEM_TIMEOUT, 15: maximum cycles MEM waits for `mem_ack` before aborting; must be ≥1.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  block can accept; equals (state==IDLE).
- `instr`  in  32  instruction word: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
- `rs_addr`, `rt_addr`  out  5  register-file read addresses.
- `rt_data`  in  32  register-file read data for rt, used as store data.
- `alu_op`  out  2  ALU opcode: 00 add, 01 sub, 10 A+immediate.
- `imm`  out  16  IR[15:0], held while IR is valid.
- `alu_result`  in  32  ALU output.
- `mem_re`, `mem_we`  out  1  memory read/write strobes.
- `mem_addr`  out  32  equals ALUOut.
- `mem_wdata`  out  32  store data register.
- `mem_rdata`  in  32  load data.
- `mem_ack`  in  1  memory completion.
- `rf_we`  out  1  register write enable.
- `rf_waddr`  out  5  register write address.
- `rf_wdata`  out  32  register write data.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  one-cycle pulse on an undecodable opcode/funct.
- `mem_err`  out  1  one-cycle pulse on a MEM timeout.
- `instr_count`  out  CNT_W  number of retired instructions.

## Operation
- Supported instructions:
  - add: op=0x00, funct=0x20.
  - sub: op=0x00, funct=0x22.
  - addi: op=0x08.
  - lw: op=0x23.
  - sw: op=0x2B.
  - Anything else is illegal.
- States and transitions:
  - IDLE: on `instr_valid` && `instr_ready`, latch IR and go to DECODE.
  - DECODE: if illegal, pulse `illegal` and go to IDLE. Otherwise go to EXECUTE.
  - EXECUTE: go to MEM for lw/sw, else go to WRITEBACK.
  - MEM, sw: on `mem_ack`, pulse `done` and go to IDLE.
  - MEM, lw: on `mem_ack`, latch MDR and go to WRITEBACK.
  - MEM, timeout: when MEM_TIMEOUT cycles elapse without `mem_ack`, pulse `mem_err` and go to IDLE.
  - WRITEBACK: pulse `done` and go to IDLE.
- `rs_addr`/`rt_addr` equal IR fields from DECODE through WRITEBACK, and are 0 in IDLE.
- `alu_op` during EXECUTE and MEM:
  - 00 for add.
  - 01 for sub.
  - 10 for addi, lw and sw.
  - 00 in every other state.
- EXECUTE latches ALUOut ← `alu_result`. For sw it also latches `mem_wdata` ← `rt_data`.
- MEM holds exactly one of `mem_re` (lw) or `mem_we` (sw) high every cycle, until `mem_ack` or timeout.
- WRITEBACK register write:
  - `rf_waddr` = rd for R-type, rt for addi/lw.
  - `rf_wdata` = ALUOut for R-type/addi, MDR for lw.
  - `rf_we` = 1 unless `rf_waddr`==0 (write to r0 suppressed; `done` still pulses).
- `instr_count` increments by 1 on every `done` and wraps modulo 2^CNT_W. It does not count `illegal` or `mem_err`.
- Reset:
  - state = IDLE, so `instr_ready`=1.
  - IR, ALUOut, MDR, `mem_wdata`, `instr_count` and the timeout counter all clear to 0.
  - All strobes and pulses are 0.
  - Reset mid-instruction discards that instruction and does not count it.

## Timing
- Handshake accept at edge T gives:
  - DECODE in cycle T+1.
  - EXECUTE in T+2.
  - WRITEBACK with `done` in T+3 for add/sub/addi.
- Back-to-back throughput: one instruction per 4 cycles. `instr_ready` is low from T+1 until the return to IDLE.
- lw:
  - MEM begins in T+3.
  - `mem_ack` sampled in MEM cycle k puts WRITEBACK in k+1.
  - Zero-wait `mem_ack` gives `done` in T+4.
- sw: `done` pulses in the MEM cycle where `mem_ack`=1.
- Illegal: `illegal` pulses in T+1 and `instr_ready` returns in T+2.
- Timeout: with no ack, the MEM_TIMEOUT-th MEM cycle asserts `mem_err` and drops strobes; IDLE follows.
  - `mem_ack` in that same final cycle counts as success, not an error.
- `done`, `illegal` and `mem_err` are mutually exclusive and never exceed 1 cycle.
- Inputs `instr`/`instr_valid` are ignored outside IDLE.

## Test plan
- Add: reset, then send 0x00221820 (add r3,r1,r2) with `alu_result`=0x0000000C. Expect `alu_op`=00 in EXECUTE; `rf_we`=1, `rf_waddr`=3, `rf_wdata`=0xC with `done` in T+3; `instr_count`=1.
- Sub and addi: send 0x00221822 (sub), then 0x20250010 (addi r5,r1,0x10). Expect `alu_op` 01 then 10, `imm`=0x0010, `rf_waddr` 3 then 5, accepts 4 cycles apart.
- lw with wait states: send 0x8C240008 with `alu_result`=0x108, `mem_ack` after 3 cycles, `mem_rdata`=0xDEADBEEF. Expect `mem_re` high 3 cycles, `mem_addr`=0x108, `rf_waddr`=4, `rf_wdata`=0xDEADBEEF.
- sw and timeout:
  - Send 0xAC240008 with `rt_data`=0x55 and immediate ack. Expect `mem_we`=1, `mem_wdata`=0x55, `done`, no `rf_we`.
  - Repeat without ack. Expect `mem_err` after 15 MEM cycles and `instr_count` unchanged.
- Illegal and r0: send 0xFC000000. Expect `illegal` pulse at T+1 and no `done`. Send 0x00220020 (add r0). Expect `done`=1 with `rf_we`=0.
- Reset mid-op: assert `reset` during MEM of a lw. Expect immediate IDLE, strobes 0, `instr_count`=0, `instr_ready`=1. Counter wrap: with CNT_W=2, 4 retirements return the count to 0.

Source files
------------

// File: rtl/exec_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : exec_cycle_ctrl
//  Brief    : Multi-cycle execution sequencer for the decode/execute path.
//             Accepts one 32-bit instruction over valid/ready and walks it
//             through DECODE, EXECUTE, optional MEM and WRITEBACK, driving
//             register-file read/write, ALU opcode and memory strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module exec_cycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,  // max MEM cycles without mem_ack (>= 1)
  parameter int CNT_W       = 16   // retired-instruction counter width
) (
  input  logic             clk,
  input  logic             reset,
  // instruction handshake
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  // register-file read side
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  input  logic [31:0]      rt_data,
  // ALU control
  output logic [1:0]       alu_op,
  output logic [15:0]      imm,
  input  logic [31:0]      alu_result,
  // data memory
  output logic             mem_re,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  // register-file write side
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  // status
  output logic             done,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;

  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_ADDI  = 6'h08;
  localparam logic [5:0] C_OP_LW    = 6'h23;
  localparam logic [5:0] C_OP_SW    = 6'h2B;
  localparam logic [5:0] C_FN_ADD   = 6'h20;
  localparam logic [5:0] C_FN_SUB   = 6'h22;

  localparam logic [1:0] C_ALU_ADD  = 2'b00;
  localparam logic [1:0] C_ALU_SUB  = 2'b01;
  localparam logic [1:0] C_ALU_ADDI = 2'b10;

  // The timeout counter only needs to hold 0 .. MEM_TIMEOUT-1.
  localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]       state_q,  state_d;
  logic [31:0]      ir_q,     ir_d;
  logic [31:0]      aluout_q, aluout_d;
  logic [31:0]      mdr_q,    mdr_d;
  logic [31:0]      wdata_q,  wdata_d;
  logic [TMO_W-1:0] tmo_q,    tmo_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // --------------------------------------------------------------------------
  // Instruction decode from the latched IR
  // --------------------------------------------------------------------------
  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_is_add;
  logic       w_is_sub;
  logic       w_is_addi;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_is_rtype;
  logic       w_legal;

  assign w_op       = ir_q[31:26];
  assign w_rs       = ir_q[25:21];
  assign w_rt       = ir_q[20:16];
  assign w_rd       = ir_q[15:11];
  assign w_funct    = ir_q[5:0];

  assign w_is_add   = (w_op == C_OP_RTYPE) && (w_funct == C_FN_ADD);
  assign w_is_sub   = (w_op == C_OP_RTYPE) && (w_funct == C_FN_SUB);
  assign w_is_addi  = (w_op == C_OP_ADDI);
  assign w_is_lw    = (w_op == C_OP_LW);
  assign w_is_sw    = (w_op == C_OP_SW);
  assign w_is_rtype = w_is_add || w_is_sub;
  assign w_legal    = w_is_rtype || w_is_addi || w_is_lw || w_is_sw;

  // --------------------------------------------------------------------------
  // MEM-phase conditions
  // --------------------------------------------------------------------------
  logic w_in_mem;
  logic w_tmo_last;
  logic w_mem_hit;
  logic w_mem_expire;
  logic w_mem_live;
  logic w_in_wb;

  assign w_in_mem     = (state_q == S_MEM);
  assign w_in_wb      = (state_q == S_WRITEBACK);
  assign w_tmo_last   = (tmo_q == C_TMO_LAST);
  assign w_mem_hit    = w_in_mem && mem_ack;
  // An ack arriving in the final allowed cycle wins over the timeout.
  assign w_mem_expire = w_in_mem && !mem_ack && w_tmo_last;
  // Strobes stay up for the whole MEM phase but drop on the expiry cycle.
  assign w_mem_live   = w_in_mem && !w_mem_expire;

  // --------------------------------------------------------------------------
  // Next-state and datapath-register update logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    wdata_d  = wdata_q;
    tmo_d    = tmo_q;

    case (state_q)
      S_IDLE: begin
        // instr_ready is implied by being in IDLE.
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = w_legal ? S_EXECUTE : S_IDLE;
      end

      S_EXECUTE: begin
        aluout_d = alu_result;
        if (w_is_sw) begin
          wdata_d = rt_data;
        end
        tmo_d   = '0;
        state_d = (w_is_lw || w_is_sw) ? S_MEM : S_WRITEBACK;
      end

      S_MEM: begin
        if (mem_ack) begin
          tmo_d = '0;
          if (w_is_lw) begin
            mdr_d   = mem_rdata;
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_IDLE;
          end
        end else if (w_tmo_last) begin
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_WRITEBACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Retired-instruction counter advances on every done pulse, wrapping freely.
  always_comb begin
    count_d = count_q;
    if (done) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State and datapath registers; reset abandons any in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      wdata_q  <= '0;
      tmo_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      wdata_q  <= wdata_d;
      tmo_q    <= tmo_d;
      count_q  <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign instr_ready = (state_q == S_IDLE);
  assign imm         = ir_q[15:0];
  assign mem_addr    = aluout_q;
  assign mem_wdata   = wdata_q;
  assign instr_count = count_q;

  // Register read addresses follow IR while an instruction is in flight.
  always_comb begin
    rs_addr = '0;
    rt_addr = '0;
    if (state_q != S_IDLE) begin
      rs_addr = w_rs;
      rt_addr = w_rt;
    end
  end

  // ALU opcode is only meaningful while EXECUTE/MEM consume the ALU result.
  always_comb begin
    alu_op = C_ALU_ADD;
    if ((state_q == S_EXECUTE) || w_in_mem) begin
      if (w_is_sub) begin
        alu_op = C_ALU_SUB;
      end else if (w_is_addi || w_is_lw || w_is_sw) begin
        alu_op = C_ALU_ADDI;
      end
    end
  end

  // Exactly one memory strobe, chosen by the access type.
  always_comb begin
    mem_re = w_mem_live && w_is_lw;
    mem_we = w_mem_live && w_is_sw;
  end

  // Register write-back; a write targeting r0 is suppressed.
  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    rf_we    = 1'b0;
    if (w_in_wb) begin
      rf_waddr = w_is_rtype ? w_rd : w_rt;
      rf_wdata = w_is_lw ? mdr_q : aluout_q;
      rf_we    = (rf_waddr != 5'd0);
    end
  end

  // Single-cycle status pulses; each is tied to a state that lasts one cycle
  // or to the cycle that leaves MEM, so they cannot overlap.
  always_comb begin
    done    = w_in_wb || (w_mem_hit && w_is_sw);
    illegal = (state_q == S_DECODE) && !w_legal;
    mem_err = w_mem_expire;
  end

endmodule
`default_nettype wire

// File: tb/tb_exec_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exec_cycle_ctrl
//  Brief    : Self-checking bench for exec_cycle_ctrl: directed vector table,
//             hand-written reset/wrap sequences and randomized instructions
//             checked against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exec_cycle_ctrl;

  localparam int MEM_TIMEOUT = 15;
  localparam int K_NONE = 0;
  localparam int K_DONE = 1;
  localparam int K_ILL  = 2;
  localparam int K_ERR  = 3;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rt_data;
  logic [1:0]  alu_op;
  logic [15:0] imm;
  logic [31:0] alu_result;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        done, illegal, mem_err;
  logic [15:0] instr_count;

  // second instance with a 2-bit counter for wrap checking
  logic        u2_instr_ready;
  logic [4:0]  u2_rs_addr, u2_rt_addr;
  logic [1:0]  u2_alu_op;
  logic [15:0] u2_imm;
  logic        u2_mem_re, u2_mem_we;
  logic [31:0] u2_mem_addr, u2_mem_wdata;
  logic        u2_rf_we;
  logic [4:0]  u2_rf_waddr;
  logic [31:0] u2_rf_wdata;
  logic        u2_done, u2_illegal, u2_mem_err;
  logic [1:0]  u2_instr_count;

  exec_cycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs_addr(rs_addr), .rt_addr(rt_addr), .rt_data(rt_data),
    .alu_op(alu_op), .imm(imm), .alu_result(alu_result), .mem_re(mem_re),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .done(done), .illegal(illegal), .mem_err(mem_err),
    .instr_count(instr_count)
  );

  exec_cycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(u2_instr_ready),
    .instr(instr), .rs_addr(u2_rs_addr), .rt_addr(u2_rt_addr), .rt_data(rt_data),
    .alu_op(u2_alu_op), .imm(u2_imm), .alu_result(alu_result), .mem_re(u2_mem_re),
    .mem_we(u2_mem_we), .mem_addr(u2_mem_addr), .mem_wdata(u2_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rf_we(u2_rf_we), .rf_waddr(u2_rf_waddr),
    .rf_wdata(u2_rf_wdata), .done(u2_done), .illegal(u2_illegal), .mem_err(u2_mem_err),
    .instr_count(u2_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] alu_res;
    logic [31:0] rt_dat;
    logic [31:0] rdata;
    int          d;       // MEM cycle carrying mem_ack (1-based), 0 = never
    int          kind;
    int          lat;     // cycle (after accept) of the terminating pulse
    logic [1:0]  aluop;
    int          rf_n;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          re_n;
    int          we_n;
  } vec_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  exp_cnt = 0;
  time acc_t = 0;
  time prev_acc_t = 0;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [31:0] i, logic [31:0] a, logic [31:0] r, logic [31:0] m,
                              int d, int k, int lat, logic [1:0] op, int rfn,
                              logic [4:0] wa, logic [31:0] wd, int ren, int wen);
    vec_t v;
    v.instr = i; v.alu_res = a; v.rt_dat = r; v.rdata = m; v.d = d;
    v.kind = k; v.lat = lat; v.aluop = op; v.rf_n = rfn; v.waddr = wa;
    v.wdata = wd; v.re_n = ren; v.we_n = wen;
    return v;
  endfunction

  // Transaction-level model: outcome of one instruction from the ISA rules.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    logic [5:0] op = v.instr[31:26];
    logic [5:0] fn = v.instr[5:0];
    logic [4:0] rt = v.instr[20:16];
    logic [4:0] rd = v.instr[15:11];
    r.kind = K_ILL; r.lat = 1; r.aluop = 2'b00; r.rf_n = 0; r.waddr = 0;
    r.wdata = 0; r.re_n = 0; r.we_n = 0;
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) begin
      r.kind = K_DONE; r.lat = 3; r.aluop = (fn == 6'h22) ? 2'b01 : 2'b00;
      r.waddr = rd; r.wdata = v.alu_res; r.rf_n = (rd != 0) ? 1 : 0;
    end else if (op == 6'h08) begin
      r.kind = K_DONE; r.lat = 3; r.aluop = 2'b10;
      r.waddr = rt; r.wdata = v.alu_res; r.rf_n = (rt != 0) ? 1 : 0;
    end else if (op == 6'h23) begin
      r.aluop = 2'b10;
      if (v.d == 0) begin
        r.kind = K_ERR; r.lat = 2 + MEM_TIMEOUT; r.re_n = MEM_TIMEOUT - 1;
      end else begin
        r.kind = K_DONE; r.lat = 3 + v.d; r.re_n = v.d;
        r.waddr = rt; r.wdata = v.rdata; r.rf_n = (rt != 0) ? 1 : 0;
      end
    end else if (op == 6'h2B) begin
      r.aluop = 2'b10;
      if (v.d == 0) begin
        r.kind = K_ERR; r.lat = 2 + MEM_TIMEOUT; r.we_n = MEM_TIMEOUT - 1;
      end else begin
        r.kind = K_DONE; r.lat = 2 + v.d; r.we_n = v.d;
      end
    end
    return r;
  endfunction

  // Drive one instruction from IDLE (called at a negedge) and check its outcome.
  task automatic apply(input vec_t v);
    int p_kind = K_NONE, p_cyc = 0, npulse = 0;
    int re_n = 0, we_n = 0, rf_n = 0, mem_bad = 0, busy_bad = 0;
    logic [4:0]  o_rs = 0, o_rt = 0, o_wa = 0;
    logic [31:0] o_wd = 0;
    logic [1:0]  o_op = 0;
    logic [15:0] o_imm = 0;
    chk("ready_idle", 32'(instr_ready), 32'd1);
    instr = v.instr; instr_valid = 1'b1; alu_result = v.alu_res;
    rt_data = v.rt_dat; mem_rdata = ~v.rdata; mem_ack = 1'b0;
    @(posedge clk);
    prev_acc_t = acc_t; acc_t = $time;
    #1;
    instr_valid = 1'b0; instr = $urandom;
    for (int c = 1; c <= 40; c++) begin
      mem_ack    = (v.d != 0) && (c == v.d + 2);
      alu_result = (c >= 3) ? ~v.alu_res : v.alu_res;
      rt_data    = (c >= 3) ? ~v.rt_dat : v.rt_dat;
      mem_rdata  = (c == v.d + 2) ? v.rdata : ~v.rdata;
      @(negedge clk);
      if (c == 1) begin o_rs = rs_addr; o_rt = rt_addr; o_imm = imm; end
      if (c == 2) o_op = alu_op;
      if (mem_re) begin
        re_n++;
        if (mem_addr !== v.alu_res || alu_op !== v.aluop) mem_bad++;
      end
      if (mem_we) begin
        we_n++;
        if (mem_addr !== v.alu_res || mem_wdata !== v.rt_dat || alu_op !== v.aluop) mem_bad++;
      end
      if (mem_re && mem_we) mem_bad++;
      if (rf_we) begin rf_n++; o_wa = rf_waddr; o_wd = rf_wdata; end
      npulse += int'(done) + int'(illegal) + int'(mem_err);
      if (done || illegal || mem_err) begin
        p_kind = done ? K_DONE : (illegal ? K_ILL : K_ERR);
        p_cyc  = c;
        break;
      end
      if (instr_ready) busy_bad++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    if (v.kind == K_DONE) exp_cnt++;
    chk("pulse_kind", 32'(p_kind), 32'(v.kind));
    chk("pulse_cycle", 32'(p_cyc), 32'(v.lat));
    chk("pulse_count", 32'(npulse), 32'd1);
    chk("rs_addr", 32'(o_rs), 32'(v.instr[25:21]));
    chk("rt_addr", 32'(o_rt), 32'(v.instr[20:16]));
    chk("imm", 32'(o_imm), 32'(v.instr[15:0]));
    chk("alu_op_exec", 32'(o_op), 32'(v.aluop));
    chk("mem_re_cycles", 32'(re_n), 32'(v.re_n));
    chk("mem_we_cycles", 32'(we_n), 32'(v.we_n));
    chk("mem_side", 32'(mem_bad), 32'd0);
    chk("rf_we_cycles", 32'(rf_n), 32'(v.rf_n));
    if (v.rf_n == 1) begin
      chk("rf_waddr", 32'(o_wa), 32'(v.waddr));
      chk("rf_wdata", o_wd, v.wdata);
    end
    chk("ready_busy", 32'(busy_bad), 32'd0);
    chk("ready_after", 32'(instr_ready), 32'd1);
    chk("no_pulse_after", 32'({done, illegal, mem_err}), 32'd0);
    chk("instr_count", 32'(instr_count), 32'(exp_cnt & 32'hFFFF));
    chk("instr_count_w2", 32'(u2_instr_count), 32'(exp_cnt % 4));
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    int sel = $urandom_range(0, 5);
    logic [4:0]  rs = 5'($urandom);
    logic [4:0]  rt = 5'($urandom);
    logic [4:0]  rd = 5'($urandom);
    logic [15:0] im = 16'($urandom);
    logic [5:0]  op;
    logic [5:0]  fn;
    v = mk(0, $urandom, $urandom, $urandom, $urandom_range(0, 4), 0, 0, 0, 0, 0, 0, 0, 0);
    case (sel)
      0: v.instr = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1: v.instr = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      2: v.instr = {6'h08, rs, rt, im};
      3: v.instr = {6'h23, rs, rt, im};
      4: v.instr = {6'h2B, rs, rt, im};
      default: begin
        op = 6'($urandom);
        fn = 6'($urandom);
        if (op == 6'h08 || op == 6'h23 || op == 6'h2B) op = 6'h3F;
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) fn = fn ^ 6'h01;
        v.instr = {op, rs, rt, im[15:6], fn};
      end
    endcase
    return model(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = 0; rt_data = 0;
    alu_result = 0; mem_rdata = 0; mem_ack = 1'b0;

    tbl[0] = mk(32'h00221820, 32'h0000000C, 0, 0, 0, K_DONE, 3, 2'b00, 1, 5'd3, 32'h0000000C, 0, 0);
    tbl[1] = mk(32'h00221822, 32'h00000007, 0, 0, 0, K_DONE, 3, 2'b01, 1, 5'd3, 32'h00000007, 0, 0);
    tbl[2] = mk(32'h20250010, 32'h00000011, 0, 0, 0, K_DONE, 3, 2'b10, 1, 5'd5, 32'h00000011, 0, 0);
    tbl[3] = mk(32'h8C240008, 32'h00000108, 0, 32'hDEADBEEF, 3, K_DONE, 6, 2'b10, 1, 5'd4, 32'hDEADBEEF, 3, 0);
    tbl[4] = mk(32'hAC240008, 32'h00000200, 32'h55, 0, 1, K_DONE, 3, 2'b10, 0, 0, 0, 0, 1);
    tbl[5] = mk(32'hAC240008, 32'h00000200, 32'h55, 0, 0, K_ERR, 17, 2'b10, 0, 0, 0, 0, 14);
    tbl[6] = mk(32'hFC000000, 0, 0, 0, 0, K_ILL, 1, 2'b00, 0, 0, 0, 0, 0);
    tbl[7] = mk(32'h00220020, 32'h00000099, 0, 0, 0, K_DONE, 3, 2'b00, 0, 0, 0, 0, 0);
    tbl[8] = mk(32'h8C240008, 32'h00000108, 0, 32'h12345678, 15, K_DONE, 18, 2'b10, 1, 5'd4, 32'h12345678, 15, 0);
    tbl[9] = mk(32'h8C200004, 32'h00000104, 0, 32'hCAFEF00D, 2, K_DONE, 5, 2'b10, 0, 0, 0, 2, 0);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_pulses", 32'({done, illegal, mem_err}), 32'd0);
    chk("rst_strobes", 32'({mem_re, mem_we, rf_we}), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_addrs", 32'({rs_addr, rt_addr, alu_op}), 32'd0);
    chk("rst_imm", 32'(imm), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    // directed vectors, back-to-back
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i]);
      if (i == 2) chk("accept_gap", 32'(acc_t - prev_acc_t), 32'd40);
    end

    // reset during MEM of a lw
    instr = 32'h8C240008; instr_valid = 1'b1; alu_result = 32'h108; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midop_mem_re", 32'(mem_re), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("midop_ready", 32'(instr_ready), 32'd1);
    chk("midop_strobes", 32'({mem_re, mem_we, rf_we}), 32'd0);
    chk("midop_pulses", 32'({done, illegal, mem_err}), 32'd0);
    chk("midop_count", 32'(instr_count), 32'd0);
    chk("midop_rs", 32'(rs_addr), 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // counter wrap on the 2-bit instance
    for (int i = 0; i < 4; i++) apply(tbl[0]);
    chk("wrap_count_w2", 32'(u2_instr_count), 32'd0);
    chk("wrap_count_w16", 32'(instr_count), 32'd4);

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      apply(rand_vec());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
